pdm_pcm_decimator: RTL and testbench

Downstream stage of the PDM microphone deserializer. Consumes packed 16-bit PDM words and popcounts each word. Sums the popcounts over a fixed number of words (boxcar decimation) and converts the sum to signed two's-complement PCM. Buffers PCM samples in a small FIFO with a valid/ready interface toward the audio output / processor side.

---
 rtl/pdm_audio_pkg.sv | 43 ++++
 rtl/pcm_sample_fifo.sv | 82 ++++++++
 rtl/pdm_pcm_decimator.sv | 134 +++++++++++++
 tb/tb_pdm_pcm_decimator.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pdm_audio_pkg.sv
// Shared constants and helpers for the PDM microphone audio path.
package pdm_audio_pkg;

  localparam int unsigned PDM_WORD_WIDTH = 16;
  localparam int unsigned PCM_WIDTH      = 16;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) begin
      r++;
    end
    return r;
  endfunction

  localparam int unsigned PDM_CNT_WIDTH = clog2(PDM_WORD_WIDTH) + 1;

  // Number of ones in a PDM word (0..PDM_WORD_WIDTH).
  function automatic logic [PDM_CNT_WIDTH-1:0] popcount(input logic [PDM_WORD_WIDTH-1:0] word);
    logic [PDM_CNT_WIDTH-1:0] n;
    n = '0;
    for (int i = 0; i < int'(PDM_WORD_WIDTH); i++) begin
      n += PDM_CNT_WIDTH'(word[i]);
    end
    return n;
  endfunction

  // Clamp a signed value into the range of a width-bit two's-complement number.
  function automatic int sat_signed(input int value, input int unsigned width);
    int max_v;
    int min_v;
    max_v = (1 << (width - 1)) - 1;
    min_v = -(1 << (width - 1));
    if (value > max_v) begin
      return max_v;
    end else if (value < min_v) begin
      return min_v;
    end
    return value;
  endfunction

endpackage

// File: rtl/pcm_sample_fifo.sv
// Synchronous PCM sample FIFO with a registered head-of-queue output.
module pcm_sample_fifo import pdm_audio_pkg::*; #(
  parameter int unsigned WIDTH = PCM_WIDTH,
  parameter int unsigned DEPTH = 8
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  clr,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata,
  output logic                  full,
  output logic                  empty,
  output logic [clog2(DEPTH):0] level
);

  localparam int unsigned PTR_W = clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rptr_q, wptr_q, rptr_nxt;
  logic [LVL_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_push, do_pop;

  assign full     = (count_q == LVL_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign level    = count_q;
  assign rdata    = head_q;
  assign rptr_nxt = rptr_q + PTR_W'(1);

  // A push on full is accepted only when a pop frees a slot in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Next level and next head value; the head follows the incoming word when the
  // FIFO is (or is about to become) empty, otherwise the next stored entry.
  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + LVL_W'(1);
      2'b01:   count_d = count_q - LVL_W'(1);
      default: count_d = count_q;
    endcase

    head_d = head_q;
    if (do_pop && (count_q > LVL_W'(1))) begin
      head_d = mem_q[rptr_nxt];
    end else if (do_push && (empty || (do_pop && (count_q == LVL_W'(1))))) begin
      head_d = wdata;
    end
  end

  // Storage array; contents need no reset because only occupied slots are read.
  always_ff @(posedge HCLK) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata;
    end
  end

  // Pointers, level and head register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      head_q  <= '0;
    end else if (clr) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      head_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PTR_W'(1);
      if (do_pop)  rptr_q <= rptr_nxt;
      count_q <= count_d;
      head_q  <= head_d;
    end
  end

endmodule

// File: rtl/pdm_pcm_decimator.sv
// PDM word popcount + boxcar decimator producing signed PCM into a small FIFO.
module pdm_pcm_decimator import pdm_audio_pkg::*; #(
  parameter int unsigned IN_WIDTH         = PDM_WORD_WIDTH,
  parameter int unsigned WORDS_PER_SAMPLE = 4,
  parameter int unsigned OUT_WIDTH        = PCM_WIDTH,
  parameter int unsigned FIFO_DEPTH       = 8
) (
  input  logic                       HCLK,
  input  logic                       HRESETn,
  input  logic                       EN,
  input  logic                       in_valid,
  input  logic [IN_WIDTH-1:0]        in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_WIDTH-1:0]       out_data,
  output logic [clog2(FIFO_DEPTH):0] fifo_level,
  output logic                       overflow,
  input  logic                       clr_ovf
);

  // L: log2 of the number of PDM bits per PCM sample.
  localparam int unsigned L      = clog2(IN_WIDTH * WORDS_PER_SAMPLE);
  localparam int unsigned SUM_W  = L + 1;
  localparam int unsigned PC_W   = clog2(IN_WIDTH) + 1;
  localparam int unsigned WCNT_W = (WORDS_PER_SAMPLE > 1) ? clog2(WORDS_PER_SAMPLE) : 1;
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(WORDS_PER_SAMPLE - 1);

  logic                 in_valid_q;
  logic                 discard_q;
  logic                 word_edge;
  logic [IN_WIDTH-1:0]  word_q;
  logic                 c0_vld_q;
  logic [PC_W-1:0]      pc_q;
  logic                 c1_vld_q;
  logic [SUM_W-1:0]     acc_q, sum_d;
  logic [WCNT_W-1:0]    wcnt_q;
  logic [OUT_WIDTH-1:0] pcm_q, pcm_d;
  logic                 pcm_stb_q;
  logic                 overflow_q;
  int                   centered;

  logic fifo_push, fifo_pop, fifo_full, fifo_empty, drop;

  assign word_edge = in_valid & ~in_valid_q;

  // Sum of the pending accumulation plus the current word, centred and scaled to PCM.
  always_comb begin
    sum_d    = acc_q + SUM_W'(pc_q);
    centered = int'(sum_d) - (1 << (L - 1));
    pcm_d    = OUT_WIDTH'(sat_signed(centered <<< (OUT_WIDTH - L), OUT_WIDTH));
  end

  // Edge capture, popcount stage and accumulator; EN low clears like reset.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      in_valid_q <= 1'b0;
      discard_q  <= 1'b1;
      word_q     <= '0;
      c0_vld_q   <= 1'b0;
      pc_q       <= '0;
      c1_vld_q   <= 1'b0;
      acc_q      <= '0;
      wcnt_q     <= '0;
      pcm_q      <= '0;
      pcm_stb_q  <= 1'b0;
    end else if (!EN) begin
      in_valid_q <= 1'b0;
      discard_q  <= 1'b1;
      word_q     <= '0;
      c0_vld_q   <= 1'b0;
      pc_q       <= '0;
      c1_vld_q   <= 1'b0;
      acc_q      <= '0;
      wcnt_q     <= '0;
      pcm_q      <= '0;
      pcm_stb_q  <= 1'b0;
    end else begin
      in_valid_q <= in_valid;
      // The deserializer emits one stale word on enable; drop the first edge.
      c0_vld_q   <= word_edge & ~discard_q;
      if (word_edge) begin
        discard_q <= 1'b0;
        word_q    <= in_data;
      end
      pc_q      <= PC_W'(popcount(PDM_WORD_WIDTH'(word_q)));
      c1_vld_q  <= c0_vld_q;
      pcm_stb_q <= 1'b0;
      if (c1_vld_q) begin
        if (wcnt_q == LAST_WORD) begin
          acc_q     <= '0;
          wcnt_q    <= '0;
          pcm_q     <= pcm_d;
          pcm_stb_q <= 1'b1;
        end else begin
          acc_q  <= sum_d;
          wcnt_q <= wcnt_q + WCNT_W'(1);
        end
      end
    end
  end

  assign fifo_pop  = ~fifo_empty & out_ready;
  assign fifo_push = pcm_stb_q & EN;
  assign drop      = fifo_push & fifo_full & ~fifo_pop;

  // Sticky overflow survives EN low; a new drop wins over clr_ovf.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= drop | (overflow_q & ~clr_ovf);
    end
  end

  pcm_sample_fifo #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .clr     (~EN),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wdata   (pcm_q),
    .rdata   (out_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign out_valid = ~fifo_empty;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_pdm_pcm_decimator.sv
// Scoreboard bench for pdm_pcm_decimator (default parameters).
module tb_pdm_pcm_decimator;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        EN = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic [3:0]  fifo_level;
  logic        overflow;
  logic        clr_ovf = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];
  int          acc_m = 0;
  int          cnt_m = 0;
  bit          discard_m = 1'b1;

  always #5 HCLK = ~HCLK;

  pdm_pcm_decimator dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .EN         (EN),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf)
  );

  // 64 PDM bits per sample: centre at 32, scale by 2^10, clip positive full scale.
  function automatic logic [15:0] expect_pcm(input int sum);
    int p;
    p = (sum - 32) * 1024;
    if (p > 32767) p = 32767;
    return p[15:0];
  endfunction

  // Scoreboard: every accepted output sample is compared with the queue head.
  always @(negedge HCLK) begin
    if (HRESETn && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_sample: got %0d, none expected", $signed(out_data));
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          errors++;
          $display("FAIL sample_data: got %0d, expected %0d", $signed(out_data), $signed(e));
        end
      end
    end
  end

  // Called at posedge+1; model tracks discard and boxcar sums.
  task automatic send_word(input logic [15:0] d, input int hold, input int gap);
    in_data  = d;
    in_valid = 1'b1;
    if (discard_m) begin
      discard_m = 1'b0;
    end else begin
      acc_m += $countones(d);
      cnt_m++;
      if (cnt_m == 4) begin
        exp_q.push_back(expect_pcm(acc_m));
        acc_m = 0;
        cnt_m = 0;
      end
    end
    repeat (hold) @(posedge HCLK);
    #1 in_valid = 1'b0;
    repeat (gap) @(posedge HCLK);
    #1;
  endtask

  task automatic send4(input logic [15:0] a, b, c, d, input int hold, input int gap);
    send_word(a, hold, gap);
    send_word(b, hold, gap);
    send_word(c, hold, gap);
    send_word(d, hold, gap);
  endtask

  task automatic model_clear();
    acc_m     = 0;
    cnt_m     = 0;
    discard_m = 1'b1;
  endtask

  task automatic wait_drain(input int max_cycles);
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < max_cycles) begin
      @(posedge HCLK);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || out_valid) begin
      errors++;
      $display("FAIL drain_timeout: pending %0d out_valid %0b, expected 0 and 0",
               exp_q.size(), out_valid);
    end
  endtask

  task automatic check_level(input string name, input int lvl, input logic ovf);
    checks++;
    if (fifo_level !== 4'(lvl)) begin
      errors++;
      $display("FAIL %s_level: got %0d, expected %0d", name, fifo_level, lvl);
    end
    checks++;
    if (overflow !== ovf) begin
      errors++;
      $display("FAIL %s_overflow: got %0b, expected %0b", name, overflow, ovf);
    end
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    repeat (3) @(posedge HCLK);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0) begin
      errors++;
      $display("FAIL reset_out: got valid %0b data %h, expected 0 0000", out_valid, out_data);
    end
    check_level("reset", 0, 1'b0);
    HRESETn = 1'b1;
    model_clear();
    @(posedge HCLK);
    #1;
  endtask

  task automatic test_full_scale();
    out_ready = 1'b0;
    send_word(16'h1234, 2, 4);  // stale word, discarded
    send_word(16'hFFFF, 2, 4);
    send_word(16'hFFFF, 2, 4);
    send_word(16'hFFFF, 2, 4);
    send_word(16'hFFFF, 1, 0);  // returns one cycle after the edge is sampled
    repeat (2) @(posedge HCLK);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: out_valid %0b, expected 0", out_valid);
    end
    @(posedge HCLK);
    #1;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL latency_rise: out_valid %0b, expected 1", out_valid);
    end
    check_level("full_scale", 1, 1'b0);
    out_ready = 1'b1;
    wait_drain(20);
  endtask

  task automatic test_patterns();
    out_ready = 1'b1;
    send4(16'h0000, 16'h0000, 16'h0000, 16'h0000, 2, 4);
    send4(16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA, 2, 4);
    send4(16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 2, 4);
    send4(16'h0FFF, 16'h0FFF, 16'h0FFF, 16'h0FFF, 2, 4);
    // Back-to-back edges every other cycle.
    send4(16'h0001, 16'h0003, 16'h0007, 16'h000F, 1, 1);
    send4(16'hF000, 16'hFF00, 16'hFFF0, 16'h8000, 1, 1);
    wait_drain(40);
  endtask

  task automatic test_held_valid();
    out_ready = 1'b1;
    EN = 1'b0;
    model_clear();
    repeat (3) @(posedge HCLK);
    #1 EN = 1'b1;
    send_word(16'hFFFF, 200, 50);  // discarded after EN rise
    for (int i = 0; i < 4; i++) send_word(16'h3FFF, 200, 50);
    wait_drain(20);
    repeat (10) @(posedge HCLK);
    #1;
    check_level("held", 0, 1'b0);
  endtask

  task automatic test_overflow();
    logic [15:0] w;
    out_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      w = 16'((1 << (k + 4)) - 1);
      send4(w, w, w, w, 2, 2);
    end
    repeat (6) @(posedge HCLK);
    #1;
    check_level("overflow_full", 8, 1'b1);
    void'(exp_q.pop_back());  // ninth sample is dropped by the DUT
    out_ready = 1'b1;
    wait_drain(30);
    check_level("overflow_drained", 0, 1'b1);
    EN = 1'b0;
    model_clear();
    repeat (2) @(posedge HCLK);
    #1;
    check_level("overflow_en_low", 0, 1'b1);
    EN = 1'b1;
    clr_ovf = 1'b1;
    @(posedge HCLK);
    #1 clr_ovf = 1'b0;
    check_level("overflow_cleared", 0, 1'b0);
  endtask

  task automatic test_push_pop_full();
    logic [15:0] w;
    out_ready = 1'b0;
    send_word(16'h5555, 2, 2);  // discarded after the EN toggle
    for (int k = 0; k < 8; k++) begin
      w = 16'((1 << (k + 2)) - 1);
      send4(w, w, w, w, 2, 2);
    end
    repeat (6) @(posedge HCLK);
    #1;
    check_level("ppf_full", 8, 1'b0);
    send_word(16'hFFF0, 2, 2);
    send_word(16'hFF00, 2, 2);
    send_word(16'hF000, 2, 2);
    send_word(16'h00FF, 1, 0);
    repeat (2) @(posedge HCLK);
    #1 out_ready = 1'b1;      // pop lands on the same edge as the push
    @(posedge HCLK);
    #1 out_ready = 1'b0;
    repeat (2) @(posedge HCLK);
    #1;
    check_level("ppf_after", 8, 1'b0);
    out_ready = 1'b1;
    wait_drain(30);
  endtask

  task automatic test_reset_mid_sample();
    out_ready = 1'b1;
    send_word(16'hFFFF, 2, 4);
    send_word(16'hFFFF, 2, 4);
    HRESETn = 1'b0;
    #2;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0) begin
      errors++;
      $display("FAIL midreset_out: got valid %0b data %h, expected 0 0000", out_valid, out_data);
    end
    check_level("midreset", 0, 1'b0);
    model_clear();
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    @(posedge HCLK);
    #1;
    send_word(16'hFFFF, 2, 4);  // fresh discard
    send4(16'h0000, 16'h0000, 16'h0000, 16'h0000, 2, 4);
    wait_drain(20);
  endtask

  initial begin
    test_reset();
    test_full_scale();
    test_patterns();
    test_held_valid();
    test_overflow();
    test_push_pop_full();
    test_reset_mid_sample();
    repeat (5) @(posedge HCLK);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_queue: pending %0d, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
